// File: rtl/div_req_sequencer_pkg.sv
// div_req_sequencer_pkg: shared widths, FSM states and the divide-by-zero quotient
package div_req_sequencer_pkg;
  localparam int DEF_WIDTH = 3;
  localparam int DEF_DEPTH = 4;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_HOLD    = 2'd2
  } state_e;
  // sliced to WIDTH by users; divide-by-zero quotient is all ones
  localparam logic [63:0] DBZ_QUOT = '1;
endpackage

// File: rtl/div_req_sequencer_if.sv
// div_req_sequencer_if: request, divider and response signals of the issue stage
interface div_req_sequencer_if
  import div_req_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_dividend;
  logic [WIDTH-1:0]       in_divisor;
  logic [WIDTH-1:0]       div_dividend;
  logic [WIDTH-1:0]       div_divisor;
  logic [WIDTH-1:0]       div_result;
  logic [WIDTH-1:0]       div_remainder;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_quotient;
  logic [WIDTH-1:0]       out_remainder;
  logic                   out_dbz;
  logic [$clog2(DEPTH):0] fifo_count;
  modport master (
    input  in_valid, in_dividend, in_divisor, div_result, div_remainder, out_ready,
    output in_ready, div_dividend, div_divisor, out_valid, out_quotient, out_remainder,
           out_dbz, fifo_count
  );
  modport slave (
    output in_valid, in_dividend, in_divisor, div_result, div_remainder, out_ready,
    input  in_ready, div_dividend, div_divisor, out_valid, out_quotient, out_remainder,
           out_dbz, fifo_count
  );
endinterface

// File: rtl/div_req_sequencer_fifo.sv
// div_req_fifo: request queue; pushes when full and pops when empty are ignored
module div_req_fifo #(
  parameter int DW    = 6,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DW-1:0]          din_i,
  output logic [DW-1:0]          dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic do_push, do_pop;
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/div_req_sequencer.sv
// div_req_sequencer: queues operand pairs, drives an external divider one pair at a time
// and returns registered quotient/remainder, resolving divide-by-zero locally
module div_req_sequencer
  import div_req_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic                clk,
  input logic                rst_n,
  div_req_sequencer_if.master bus_io
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, quot_q, quot_d, rem_q, rem_d;
  logic valid_q, valid_d, dbz_q, dbz_d;
  logic push, pop, full, empty;
  logic [2*WIDTH-1:0] head;
  div_req_fifo #(.DW(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .din_i  ({bus_io.in_dividend, bus_io.in_divisor}),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(bus_io.fifo_count)
  );
  assign push = bus_io.in_valid && !full;
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    valid_d = valid_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        pop     = !empty;
        state_d = empty ? S_IDLE : S_COMPUTE;
      end
      S_COMPUTE: begin
        state_d = S_HOLD;
        valid_d = 1'b1;
        dbz_d   = opb_q == '0;
        quot_d  = dbz_d ? DBZ_QUOT[WIDTH-1:0] : bus_io.div_result;
        rem_d   = dbz_d ? opa_q : bus_io.div_remainder;
      end
      S_HOLD:
        if (bus_io.out_ready) begin
          valid_d = 1'b0;
          pop     = !empty;
          state_d = empty ? S_IDLE : S_COMPUTE;
        end
      default: state_d = S_IDLE;
    endcase
    // operands only move on a pop so the divider sees them steady until the next pop
    opa_d = pop ? head[2*WIDTH-1:WIDTH] : opa_q;
    opb_d = pop ? head[WIDTH-1:0] : opb_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      dbz_q   <= dbz_d;
    end
  assign bus_io.in_ready      = !full;
  assign bus_io.div_dividend  = opa_q;
  assign bus_io.div_divisor   = opb_q;
  assign bus_io.out_valid     = valid_q;
  assign bus_io.out_quotient  = quot_q;
  assign bus_io.out_remainder = rem_q;
  assign bus_io.out_dbz       = dbz_q;
endmodule

// File: tb/tb_div_req_sequencer.sv
// tb_div_req_sequencer: directed table, corner sequences and random traffic checked
// against an arithmetic reference queue
module tb_div_req_sequencer;
  localparam int W = 3;
  localparam int D = 4;
  typedef struct {int q; int r; int dbz;} resp_t;
  typedef struct {int a; int b; int q; int r; int dbz;} vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  div_req_sequencer_if #(.WIDTH(W), .DEPTH(D)) bus ();
  div_req_sequencer #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));
  // divider stand-in; junk on zero divisor so a sequencer that trusts it gets caught
  assign bus.div_result    = bus.div_divisor == 0 ? 3'd5 : bus.div_dividend / bus.div_divisor;
  assign bus.div_remainder = bus.div_divisor == 0 ? 3'd2 : bus.div_dividend % bus.div_divisor;
  resp_t exp_q[$];
  resp_t got_q[$];
  vec_t vecs[6];
  int passed = 0, total = 0, n_acc = 0, base, acc0;
  int snap;
  task automatic chk(string name, int got, int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask
  function automatic resp_t ref_div(int a, int b);
    resp_t x;
    if (b == 0) begin x.q = (1 << W) - 1; x.r = a; x.dbz = 1; end
    else begin x.q = a / b; x.r = a % b; x.dbz = 0; end
    return x;
  endfunction
  // one clock: record what fires at the coming edge, then return at the next falling edge
  task automatic cyc();
    resp_t g, e;
    #1;
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(ref_div(int'(bus.in_dividend), int'(bus.in_divisor)));
      n_acc++;
    end
    if (bus.out_valid && bus.out_ready) begin
      g.q = int'(bus.out_quotient); g.r = int'(bus.out_remainder); g.dbz = int'(bus.out_dbz);
      got_q.push_back(g);
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL sb_spurious: response q=%0d r=%0d with nothing outstanding", g.q, g.r);
      end else begin
        e = exp_q.pop_front();
        chk("sb_quot", g.q, e.q);
        chk("sb_rem", g.r, e.r);
        chk("sb_dbz", g.dbz, e.dbz);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic push(int a, int b);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1; bus.in_dividend = W'(a); bus.in_divisor = W'(b);
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = bus.in_ready;
      cyc();
    end
    bus.in_valid = 1'b0;
    if (!acc) begin total++; $display("FAIL push_timeout: in_ready got 0 required 1"); end
  endtask
  task automatic drain();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !bus.out_valid && bus.fifo_count == 0) break;
      cyc();
    end
    chk("drain_outstanding", exp_q.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.in_valid = 1'b0; bus.in_dividend = '0; bus.in_divisor = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_fifo_count", bus.fifo_count, 0);
    chk("rst_div_dividend", bus.div_dividend, 0);
    chk("rst_out_quotient", bus.out_quotient, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    // single request latency
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_dividend = 3'd6; bus.in_divisor = 3'd2;
    cyc();
    bus.in_valid = 1'b0;
    chk("t1_count_n", bus.fifo_count, 1);
    chk("t1_valid_n", bus.out_valid, 0);
    cyc();
    chk("t1_div_dividend", bus.div_dividend, 6);
    chk("t1_div_divisor", bus.div_divisor, 2);
    chk("t1_valid_n1", bus.out_valid, 0);
    chk("t1_count_n1", bus.fifo_count, 0);
    cyc();
    chk("t1_valid_n2", bus.out_valid, 1);
    chk("t1_quot", bus.out_quotient, 3);
    chk("t1_rem", bus.out_remainder, 0);
    chk("t1_dbz", bus.out_dbz, 0);
    drain();
    // table: ordered responses including divide-by-zero and boundary operands
    vecs[0] = '{7, 3, 2, 1, 0};
    vecs[1] = '{5, 0, 7, 5, 1};
    vecs[2] = '{4, 5, 0, 4, 0};
    vecs[3] = '{0, 0, 7, 0, 1};
    vecs[4] = '{7, 1, 7, 0, 0};
    vecs[5] = '{6, 7, 0, 6, 0};
    base = got_q.size();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) push(vecs[i].a, vecs[i].b);
    drain();
    chk("tbl_count", got_q.size() - base, 6);
    for (int i = 0; i < 6 && base + i < got_q.size(); i++) begin
      chk($sformatf("tbl%0d_quot", i), got_q[base+i].q, vecs[i].q);
      chk($sformatf("tbl%0d_rem", i), got_q[base+i].r, vecs[i].r);
      chk($sformatf("tbl%0d_dbz", i), got_q[base+i].dbz, vecs[i].dbz);
    end
    // fill: one in flight plus DEPTH queued, extras refused
    bus.out_ready = 1'b0;
    acc0 = n_acc; base = got_q.size();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_dividend = W'($urandom); bus.in_divisor = W'($urandom);
      cyc();
    end
    chk("fill_count", bus.fifo_count, D);
    chk("fill_in_ready", bus.in_ready, 0);
    chk("fill_accepted", n_acc - acc0, D + 1);
    bus.out_ready = 1'b1;
    #1 chk("fill_no_pushthrough", bus.in_ready, 0);
    cyc();
    chk("fill_count_after_pop", bus.fifo_count, D - 1);
    drain();
    chk("fill_returned", got_q.size() - base, D + 1);
    // backpressure: outputs and operands frozen while held
    bus.out_ready = 1'b0;
    push(3, 2);
    for (int i = 0; i < 10 && !bus.out_valid; i++) cyc();
    chk("bp_valid", bus.out_valid, 1);
    snap = {bus.out_quotient, bus.out_remainder, bus.out_dbz, bus.div_dividend, bus.div_divisor};
    push(6, 4);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bp_stable", {bus.out_quotient, bus.out_remainder, bus.out_dbz, bus.div_dividend,
                        bus.div_divisor}, snap);
    end
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    chk("bp_release_valid1", bus.out_valid, 0);
    cyc();
    chk("bp_release_valid2", bus.out_valid, 1);
    chk("bp_release_quot", bus.out_quotient, 1);
    chk("bp_release_rem", bus.out_remainder, 2);
    drain();
    // simultaneous push and pop keeps the count
    bus.out_ready = 1'b0;
    push(1, 1); push(2, 1); push(3, 1);
    chk("pp_count_before", bus.fifo_count, 2);
    chk("pp_hold", bus.out_valid, 1);
    bus.in_valid = 1'b1; bus.in_dividend = 3'd4; bus.in_divisor = 3'd1; bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    chk("pp_count_after", bus.fifo_count, 2);
    drain();
    // random traffic, wraps the pointers many times
    for (int i = 0; i < 120; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_dividend = W'($urandom); bus.in_divisor = W'($urandom_range(0, 7));
      bus.out_ready = $urandom_range(0, 9) < 7;
      cyc();
    end
    drain();
    // async reset in COMPUTE with three queued
    bus.out_ready = 1'b0;
    push(7, 1); push(2, 2); push(3, 3); push(4, 4);
    bus.out_ready = 1'b1;
    push(5, 5);
    bus.out_ready = 1'b0;
    chk("ar_count_before", bus.fifo_count, 3);
    chk("ar_quot_before", bus.out_quotient, 7);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("ar_out_valid", bus.out_valid, 0);
    chk("ar_fifo_count", bus.fifo_count, 0);
    chk("ar_quot", bus.out_quotient, 0);
    chk("ar_div_dividend", bus.div_dividend, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_dividend = 3'd5; bus.in_divisor = 3'd2;
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    chk("ar_post_valid1", bus.out_valid, 0);
    chk("ar_post_dividend", bus.div_dividend, 5);
    cyc();
    chk("ar_post_valid2", bus.out_valid, 1);
    chk("ar_post_quot", bus.out_quotient, 2);
    chk("ar_post_rem", bus.out_remainder, 1);
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
